// File: rtl/store_drain_buffer.sv
// Post-commit store buffer: execute fills entries by stid, commit marks them in order,
// and a req/gnt/ack FSM drains committed stores one at a time to the L1 D-cache.
module store_drain_buffer #(
  parameter int cwd = 4,
  parameter int ssz = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_wena,
  input  logic [7:0]      st_stid,
  input  logic [63:0]     st_addr,
  input  logic [63:0]     st_data,
  input  logic [1:0]      st_size,
  input  logic [cwd-1:0]  com_store,
  input  logic            redir,
  input  logic            fence_req,
  output logic            mem_req,
  output logic [63:0]     mem_addr,
  output logic [63:0]     mem_data,
  output logic [7:0]      mem_strb,
  input  logic            mem_gnt,
  input  logic            mem_ack,
  output logic [7:0]      drn_stid,
  output logic            empty,
  output logic            fence_done
);

  localparam int IW = $clog2(ssz);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e         state_q, state_d;
  logic [ssz-1:0] wr_q, wr_d, cm_q, cm_d;
  logic [7:0]     com_ptr_q, com_ptr_d, drn_ptr_q, drn_ptr_d;
  logic           fence_pend_q, fence_pend_d;
  logic [63:0]    mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [7:0]     mem_strb_q, mem_strb_d;

  logic [63:0]    addr_mem [ssz];
  logic [63:0]    data_mem [ssz];
  logic [1:0]     size_mem [ssz];

  logic [IW-1:0]  wr_idx, drn_idx;
  logic           wr_ok;
  logic [7:0]     ncom;
  logic [7:0]     lane_ptr;
  logic           commit_err;
  logic [2:0]     boff;
  logic [7:0]     size_mask;
  logic [15:0]    strb_wide;
  logic           unused_bits;

  assign wr_idx      = st_stid[IW-1:0];
  assign drn_idx     = drn_ptr_q[IW-1:0];
  assign wr_ok       = st_wena & ~cm_q[wr_idx];
  assign unused_bits = ^{st_stid[7:IW], lane_ptr[7:IW]};

  // Payload storage carries no reset; wr/cm qualify every entry.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      addr_mem[wr_idx] <= st_addr;
      data_mem[wr_idx] <= st_data;
      size_mem[wr_idx] <= st_size;
    end
  end

  always_comb begin
    boff = addr_mem[drn_idx][2:0];
    case (size_mem[drn_idx])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    strb_wide = {8'h00, size_mask} << boff;
  end

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    cm_d         = cm_q;
    com_ptr_d    = com_ptr_q;
    drn_ptr_d    = drn_ptr_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_strb_d   = mem_strb_q;
    ncom         = '0;
    lane_ptr     = '0;
    commit_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cm_q[drn_idx]) begin
          mem_addr_d = {addr_mem[drn_idx][63:3], 3'b000};
          mem_data_d = data_mem[drn_idx] << {boff, 3'b000};
          mem_strb_d = strb_wide[7:0];
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) begin
          wr_d[drn_idx] = 1'b0;
          cm_d[drn_idx] = 1'b0;
          drn_ptr_d     = drn_ptr_q + 8'd1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_ok) wr_d[wr_idx] = 1'b1;

    for (int i = 0; i < cwd; i++) ncom = ncom + 8'(com_store[i]);
    for (int i = 0; i < cwd; i++) begin
      if (8'(i) < ncom) begin
        lane_ptr = com_ptr_q + 8'(i);
        if (!wr_d[lane_ptr[IW-1:0]]) commit_err = 1'b1;
        cm_d[lane_ptr[IW-1:0]] = 1'b1;
      end
    end
    com_ptr_d = com_ptr_q + ncom;

    // Redirect runs after commit so stores committed this cycle keep their data.
    if (redir) begin
      for (int j = 0; j < ssz; j++) begin
        if (!cm_d[j]) wr_d[j] = 1'b0;
      end
    end

    fence_pend_d = (fence_pend_q & ~empty) | fence_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_q         <= '0;
      cm_q         <= '0;
      com_ptr_q    <= '0;
      drn_ptr_q    <= '0;
      fence_pend_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_strb_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      cm_q         <= cm_d;
      com_ptr_q    <= com_ptr_d;
      drn_ptr_q    <= drn_ptr_d;
      fence_pend_q <= fence_pend_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_strb_q   <= mem_strb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(st_wena && cm_q[wr_idx]));
      assert (!commit_err);
      assert ((com_ptr_q - drn_ptr_q) <= 8'(ssz));
    end
  end

  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_strb   = mem_strb_q;
  assign drn_stid   = drn_ptr_q;
  assign empty      = (com_ptr_q == drn_ptr_q) && (state_q == S_IDLE);
  assign fence_done = fence_pend_q & empty;

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: a D-cache responder pops a scoreboard filled at commit
// time, and per-scenario tasks check timing, redirect, wrap, fence and reset behaviour.
module tb_store_drain_buffer;

  localparam int CWD = 4;
  localparam int SSZ = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           st_wena;
  logic [7:0]     st_stid;
  logic [63:0]    st_addr, st_data;
  logic [1:0]     st_size;
  logic [CWD-1:0] com_store;
  logic           redir, fence_req;
  logic           mem_req, mem_gnt, mem_ack;
  logic [63:0]    mem_addr, mem_data;
  logic [7:0]     mem_strb, drn_stid;
  logic           empty, fence_done;

  always #5 clk = ~clk;

  store_drain_buffer #(.cwd(CWD), .ssz(SSZ)) dut (
    .clk(clk), .rst(rst), .st_wena(st_wena), .st_stid(st_stid), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size), .com_store(com_store), .redir(redir),
    .fence_req(fence_req), .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_strb(mem_strb), .mem_gnt(mem_gnt), .mem_ack(mem_ack), .drn_stid(drn_stid),
    .empty(empty), .fence_done(fence_done)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  stid;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic [63:0] m_addr [256];
  logic [63:0] m_data [256];
  logic [1:0]  m_size [256];
  logic [7:0]  m_com;

  bit pending = 0;
  int wait_cnt = 0;
  int grants = 0;
  int ack_cyc = 0;
  bit hold_ack = 0;
  bit ack_inj = 0;
  int ack_delay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // D-cache model: grants in the REQ cycle, acks ack_delay cycles into WAIT.
  initial begin
    exp_t e;
    mem_gnt = 1'b0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_ack = ack_inj;
      if (rst) begin
        pending = 0;
        sbq.delete();
      end else if (pending) begin
        if (!hold_ack) begin
          if (wait_cnt == 0) begin
            mem_ack = 1'b1;
            pending = 0;
            ack_cyc = cyc;
          end else begin
            wait_cnt--;
          end
        end
      end else if (mem_req) begin
        mem_gnt  = 1'b1;
        pending  = 1;
        wait_cnt = ack_delay;
        grants++;
        checks++;
        if (sbq.size() == 0) begin
          $display("[TB] FAIL sb_unexpected_req: got request for stid %0d, expected none", drn_stid);
        end else begin
          e = sbq.pop_front();
          if ({mem_addr, mem_data, mem_strb, drn_stid} !== {e.addr, e.data, e.strb, e.stid})
            $display("[TB] FAIL sb_drain: got addr=%h data=%h strb=%h stid=%0d, want addr=%h data=%h strb=%h stid=%0d",
                     mem_addr, mem_data, mem_strb, drn_stid, e.addr, e.data, e.strb, e.stid);
          else
            passes++;
        end
      end
    end
  end

  task automatic do_write(input logic [7:0] id, input logic [63:0] a, input logic [63:0] d,
                          input logic [1:0] sz);
    st_wena = 1'b1;
    st_stid = id;
    st_addr = a;
    st_data = d;
    st_size = sz;
    m_addr[id] = a;
    m_data[id] = d;
    m_size[id] = sz;
    @(negedge clk);
    st_wena = 1'b0;
  endtask

  task automatic do_commit(input int n, input bit rd);
    exp_t e;
    int off;
    logic [7:0] id;
    com_store = '0;
    for (int i = 0; i < n; i++) com_store[i] = 1'b1;
    redir = rd;
    for (int k = 0; k < n; k++) begin
      id     = m_com;
      off    = int'(m_addr[id][2:0]);
      e.addr = m_addr[id] & ~64'h7;
      e.data = '0;
      e.strb = '0;
      for (int b = 0; b < 8; b++) begin
        if (b >= off && b < off + (1 << m_size[id])) e.strb[b] = 1'b1;
        if (b >= off) e.data[8*b +: 8] = m_data[id][8*(b-off) +: 8];
      end
      e.stid = id;
      sbq.push_back(e);
      m_com++;
    end
    @(negedge clk);
    com_store = '0;
    redir = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      if (sbq.size() == 0 && !pending && empty === 1'b1) done = 1;
      else @(negedge clk);
    end
    checks++;
    if (!done) $display("[TB] FAIL %s_drain_timeout: got queue=%0d empty=%b, want all drained", name, sbq.size(), empty);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_com = '0;
    checks++; if (mem_req !== 1'b0) $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); else passes++;
    checks++; if (mem_addr !== 64'h0) $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); else passes++;
    checks++; if (mem_data !== 64'h0) $display("[TB] FAIL reset_mem_data: got %h want 0", mem_data); else passes++;
    checks++; if (mem_strb !== 8'h0) $display("[TB] FAIL reset_mem_strb: got %h want 0", mem_strb); else passes++;
    checks++; if (drn_stid !== 8'h0) $display("[TB] FAIL reset_drn_stid: got %0d want 0", drn_stid); else passes++;
    checks++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b want 1", empty); else passes++;
    checks++; if (fence_done !== 1'b0) $display("[TB] FAIL reset_fence_done: got %b want 0", fence_done); else passes++;
  endtask

  task automatic test_basic();
    test_reset();
    ack_delay = 0;
    do_write(8'd0, 64'h8000_0005, 64'hAB, 2'd0);
    do_commit(1, 0);
    checks++; if (mem_req !== 1'b0) $display("[TB] FAIL basic_req_early: got %b want 0", mem_req); else passes++;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) $display("[TB] FAIL basic_req: got %b want 1", mem_req); else passes++;
    checks++; if (mem_addr !== 64'h8000_0000) $display("[TB] FAIL basic_addr: got %h want 80000000", mem_addr); else passes++;
    checks++; if (mem_strb !== 8'h20) $display("[TB] FAIL basic_strb: got %h want 20", mem_strb); else passes++;
    checks++; if (mem_data !== 64'h0000_AB00_0000_0000) $display("[TB] FAIL basic_data: got %h want 0000ab0000000000", mem_data); else passes++;
    wait_drain("basic", 20);
    checks++; if (drn_stid !== 8'd1) $display("[TB] FAIL basic_drn_stid: got %0d want 1", drn_stid); else passes++;
    checks++; if (empty !== 1'b1) $display("[TB] FAIL basic_empty: got %b want 1", empty); else passes++;
  endtask

  task automatic test_multi_commit();
    int cnt = 0;
    test_reset();
    for (int i = 0; i < 4; i++) do_write(8'(i), 64'h1000 + 64'(8*i), {$urandom, $urandom}, 2'd3);
    do_commit(4, 0);
    while (drn_stid !== 8'd4 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (drn_stid !== 8'd4 || cnt < 12) $display("[TB] FAIL multi_drain: got drn_stid=%0d after %0d cycles, want 4 after >=12", drn_stid, cnt);
    else passes++;
    wait_drain("multi", 20);
  endtask

  task automatic test_redirect();
    int g0;
    test_reset();
    for (int i = 0; i < 3; i++) do_write(8'(i), 64'h2000 + 64'(i), {$urandom, $urandom}, 2'd1);
    g0 = grants;
    do_commit(1, 1);
    wait_drain("redir", 30);
    repeat (6) @(negedge clk);
    checks++; if (grants - g0 !== 1) $display("[TB] FAIL redir_grants: got %0d want 1", grants - g0); else passes++;
    checks++; if (dut.wr_q[2:1] !== 2'b00) $display("[TB] FAIL redir_wr: got %b want 00", dut.wr_q[2:1]); else passes++;
    checks++; if (dut.com_ptr_q !== 8'd1) $display("[TB] FAIL redir_com_ptr: got %0d want 1", dut.com_ptr_q); else passes++;
    checks++; if (drn_stid !== 8'd1) $display("[TB] FAIL redir_drn_stid: got %0d want 1", drn_stid); else passes++;
    do_write(8'd1, 64'h3003, 64'h1122_3344, 2'd2);
    do_write(8'd2, 64'h3006, 64'h5566, 2'd1);
    do_commit(2, 0);
    wait_drain("redir_refill", 30);
    checks++; if (drn_stid !== 8'd3) $display("[TB] FAIL redir_refill_stid: got %0d want 3", drn_stid); else passes++;
  endtask

  task automatic test_wrap();
    int g0;
    int guard;
    logic [7:0] occ;
    test_reset();
    ack_delay = 1;
    g0 = grants;
    for (int k = 0; k < 300; k++) begin
      guard = 0;
      occ = m_com - drn_stid;
      while (occ >= 8'd12 && guard < 50) begin
        @(negedge clk);
        guard++;
        occ = m_com - drn_stid;
      end
      do_write(8'(k), {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      do_commit(1, 0);
    end
    wait_drain("wrap", 200);
    checks++; if (grants - g0 !== 300) $display("[TB] FAIL wrap_grants: got %0d want 300", grants - g0); else passes++;
    checks++; if (drn_stid !== 8'd44) $display("[TB] FAIL wrap_drn_stid: got %0d want 44", drn_stid); else passes++;
    ack_delay = 0;
  endtask

  task automatic test_fence();
    int pulses = 0;
    int done_cyc = -1;
    bit fin = 0;
    test_reset();
    ack_delay = 5;
    for (int i = 0; i < 3; i++) do_write(8'(i), 64'h4000 + 64'(8*i), {$urandom, $urandom}, 2'd3);
    do_commit(3, 0);
    fence_req = 1'b1;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      fence_req = 1'b0;
      if (fence_done === 1'b1) begin
        pulses++;
        done_cyc = cyc;
      end
      if (empty === 1'b1 && sbq.size() == 0 && !pending) fin = 1;
    end
    repeat (3) begin
      @(negedge clk);
      if (fence_done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) $display("[TB] FAIL fence_pulses: got %0d want 1", pulses); else passes++;
    checks++; if (done_cyc !== ack_cyc + 1) $display("[TB] FAIL fence_timing: got cycle %0d want %0d", done_cyc, ack_cyc + 1); else passes++;
    fence_req = 1'b1;
    @(negedge clk);
    fence_req = 1'b0;
    checks++; if (fence_done !== 1'b1) $display("[TB] FAIL fence_empty_next: got %b want 1", fence_done); else passes++;
    @(negedge clk);
    checks++; if (fence_done !== 1'b0) $display("[TB] FAIL fence_empty_single: got %b want 0", fence_done); else passes++;
    ack_delay = 0;
  endtask

  task automatic test_reset_in_wait();
    int g0;
    int guard = 0;
    test_reset();
    hold_ack = 1;
    do_write(8'd0, 64'h5000, 64'hDEAD_BEEF, 2'd2);
    do_commit(1, 0);
    while (!pending && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (!pending) $display("[TB] FAIL rstwait_grant: got no grant within %0d cycles, want grant", guard); else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_com = '0;
    hold_ack = 0;
    checks++; if (mem_req !== 1'b0) $display("[TB] FAIL rstwait_mem_req: got %b want 0", mem_req); else passes++;
    checks++; if (empty !== 1'b1) $display("[TB] FAIL rstwait_empty: got %b want 1", empty); else passes++;
    checks++; if (drn_stid !== 8'd0) $display("[TB] FAIL rstwait_drn_stid: got %0d want 0", drn_stid); else passes++;
    g0 = grants;
    ack_inj = 1;
    repeat (2) @(negedge clk);
    ack_inj = 0;
    repeat (6) @(negedge clk);
    checks++; if (drn_stid !== 8'd0) $display("[TB] FAIL rstwait_late_ack: got drn_stid=%0d want 0", drn_stid); else passes++;
    checks++; if (grants !== g0) $display("[TB] FAIL rstwait_no_req: got %0d new grants want 0", grants - g0); else passes++;
  endtask

  initial begin
    st_wena   = 1'b0;
    st_stid   = '0;
    st_addr   = '0;
    st_data   = '0;
    st_size   = '0;
    com_store = '0;
    redir     = 1'b0;
    fence_req = 1'b0;
    m_com     = '0;
    test_reset();
    test_basic();
    test_multi_commit();
    test_redirect();
    test_wrap();
    test_fence();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
